// File: rtl/exp_add_sched.sv
// Round-robin scheduler sharing one exponent adder among NREQ requesters.
// Operands are registered into the adder; one tagged result is buffered with backpressure.
//
//   state | meaning
//   IDLE  | no op in flight, result buffer empty
//   ISSUE | operands held on add_*, adder evaluating
//   HOLD  | result in buffer, resp_valid high until taken
module exp_add_sched #(
  parameter int NREQ = 3,
  parameter int W    = 13,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_cin,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_sum,
  output logic              resp_cout,
  input  logic              resp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] tag;
  logic           accept;
  logic           found;
  logic           grant;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   sidx;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           sel_sub;

  // A grant is never offered while reset is asserted, since it would not be taken.
  assign accept = reset_n & ((state == IDLE) | ((state == HOLD) & resp_ready));

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sidx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sidx = {1'b0, rr} + (IDW+1)'(k);
      if (sidx >= (IDW+1)'(NREQ)) sidx = sidx - (IDW+1)'(NREQ);
      if (!found && req_valid[sidx[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = sidx[IDW-1:0];
      end
    end
  end

  assign grant     = accept & found;
  assign req_ready = grant ? (NREQ'(1) << grant_idx) : '0;

  assign sel_a   = req_a[grant_idx*W +: W];
  assign sel_b   = req_b[grant_idx*W +: W];
  assign sel_sub = req_sub[grant_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = HOLD;
      HOLD:    if (resp_ready) state_next = grant ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr        <= '0;
      tag       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      resp_id   <= '0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
    end else begin
      if (grant) begin
        // Subtract is A + ~B + 1 so the shared adder needs no mode input.
        add_a   <= sel_a;
        add_b   <= sel_sub ? ~sel_b : sel_b;
        add_cin <= sel_sub;
        tag     <= grant_idx;
        rr      <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      end
      if (state == ISSUE) begin
        resp_sum  <= add_sum;
        resp_cout <= add_cout;
        resp_id   <= tag;
      end
    end
  end

  assign resp_valid = (state == HOLD);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_exp_add_sched.sv
// Bench for exp_add_sched: directed scenarios with literal expectations, then random traffic
// checked every cycle against an operation-level reference model.
module tb_exp_add_sched;
  localparam int NREQ = 3;
  localparam int W    = 13;
  localparam int IDW  = 2;
  localparam int MASK = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_cin;
  logic [W-1:0]      add_sum;
  logic              add_cout;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_cout;
  logic              resp_ready;
  logic              busy;

  always #5 clk = ~clk;

  // Shared adder seen by the scheduler.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  exp_add_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_cout(resp_cout), .resp_ready(resp_ready), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one op in flight, one buffered result, round-robin pointer.
  int m_rr = 0;
  bit m_inf = 0;
  int m_inf_id = 0, m_inf_sum = 0, m_inf_cout = 0;
  bit m_pend = 0;
  int m_id = 0, m_sum = 0, m_cout = 0;
  int m_add_a = 0, m_add_b = 0, m_add_cin = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit s);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_sub[i]      = s;
  endtask

  // Compare the DUT against the model for the current cycle, then advance the model over the edge.
  task automatic step();
    bit acc;
    int g, idx, a, b, exp_rdy;
    #1;
    acc = reset_n && !m_inf && (!m_pend || resp_ready);
    g = -1;
    if (acc)
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    exp_rdy = (g >= 0) ? (1 << g) : 0;
    check("req_ready", int'(req_ready), exp_rdy);
    check("resp_valid", int'(resp_valid), int'(m_pend));
    check("resp_id", int'(resp_id), m_id);
    check("resp_sum", int'(resp_sum), m_sum);
    check("resp_cout", int'(resp_cout), m_cout);
    check("busy", int'(busy), int'(m_inf || m_pend));
    check("add_a", int'(add_a), m_add_a);
    check("add_b", int'(add_b), m_add_b);
    check("add_cin", int'(add_cin), m_add_cin);
    if (!reset_n) begin
      m_rr = 0; m_inf = 0; m_pend = 0;
      m_id = 0; m_sum = 0; m_cout = 0;
      m_add_a = 0; m_add_b = 0; m_add_cin = 0;
    end else if (m_inf) begin
      m_pend = 1; m_inf = 0;
      m_id = m_inf_id; m_sum = m_inf_sum; m_cout = m_inf_cout;
    end else begin
      if (m_pend && resp_ready) m_pend = 0;
      if (g >= 0) begin
        a = int'(req_a[g*W +: W]);
        b = int'(req_b[g*W +: W]);
        m_inf = 1;
        m_inf_id = g;
        if (req_sub[g]) begin
          m_inf_sum  = (a - b) & MASK;
          m_inf_cout = (a >= b) ? 1 : 0;
          m_add_b    = (~b) & MASK;
        end else begin
          m_inf_sum  = (a + b) & MASK;
          m_inf_cout = (a + b > MASK) ? 1 : 0;
          m_add_b    = b;
        end
        m_add_a   = a;
        m_add_cin = int'(req_sub[g]);
        m_rr      = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    step();
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_add_a", int'(add_a), 0);
    reset_n = 1'b1;

    // Add with carry into bit 12.
    set_req(0, 'h0FFF, 'h0001, 1'b0);
    req_valid = 3'b001;
    #1 check("t1_grant", int'(req_ready), 'b001);
    step();
    req_valid = '0;
    step();
    check("t1_valid", int'(resp_valid), 1);
    check("t1_id", int'(resp_id), 0);
    check("t1_sum", int'(resp_sum), 'h1000);
    check("t1_cout", int'(resp_cout), 0);

    // Subtract with borrow.
    set_req(1, 'h03FF, 'h0400, 1'b1);
    req_valid = 3'b010;
    step();
    check("t2_add_b", int'(add_b), 'h1BFF);
    check("t2_add_cin", int'(add_cin), 1);
    req_valid = '0;
    step();
    check("t2_sum", int'(resp_sum), 'h1FFF);
    check("t2_cout", int'(resp_cout), 0);
    check("t2_id", int'(resp_id), 1);

    // Wrap-around add.
    set_req(2, 'h1FFF, 'h0001, 1'b0);
    req_valid = 3'b100;
    step();
    req_valid = '0;
    step();
    check("t3_sum", int'(resp_sum), 0);
    check("t3_cout", int'(resp_cout), 1);
    check("t3_id", int'(resp_id), 2);

    // All requesters busy: round-robin every second cycle.
    for (int i = 0; i < NREQ; i++) set_req(i, 16 * i + 3, i, 1'b0);
    req_valid = 3'b111;
    for (int k = 0; k < 8; k++) begin
      #1 check("t4_grant", int'(req_ready), (k % 2 == 0) ? (1 << ((k / 2) % 3)) : 0);
      if (k % 2 == 0 && k >= 2) check("t4_id", int'(resp_id), (k / 2 - 1) % 3);
      step();
    end
    req_valid = '0;
    step();

    // Backpressure on a held result, then fire and grant together.
    set_req(0, 'h0123, 'h0456, 1'b0);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    resp_ready = 1'b0;
    set_req(0, 'h0AAA, 'h0555, 1'b1);
    req_valid = 3'b001;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_ready_blocked", int'(req_ready), 0);
      check("t5_busy", int'(busy), 1);
      check("t5_sum_held", int'(resp_sum), 'h0579);
      step();
    end
    resp_ready = 1'b1;
    #1 check("t5_fire_grant", int'(req_ready), 'b001);
    step();
    check("t5_valid_drop", int'(resp_valid), 0);
    req_valid = '0;
    step();
    check("t5_new_valid", int'(resp_valid), 1);
    check("t5_new_sum", int'(resp_sum), 'h0555);
    check("t5_new_cout", int'(resp_cout), 1);

    // Reset while an op is in flight drops it.
    set_req(1, 'h0100, 'h0001, 1'b0);
    req_valid = 3'b010;
    step();
    req_valid = '0;
    reset_n = 1'b0;
    step();
    check("t6_valid", int'(resp_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_add_a", int'(add_a), 0);
    check("t6_sum", int'(resp_sum), 0);
    reset_n = 1'b1;
    step();
    step();
    check("t6_no_resp", int'(resp_valid), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      req_valid  = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'($urandom));
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
